gate_truth_checker: RTL and testbench

Sequential stimulus and checker stage for the 2:1-mux gate bank (AND, OR, NAND, NOR, XOR, NOT, XNOR built from muxes). On `start`, it drives operands `a` and `b` through all four input combinations into the bank, optionally repeating the sweep. After a settle delay it samples the seven gate outputs and compares them against the golden truth table. It reports a sticky per-gate fail mask, the first failing vector and a pass flag, using a `start`/`busy`/`done` handshake so a top-level self-test controller can sequence it.

---
 rtl/gate_chk_pkg.sv | 21 ++
 rtl/gate_truth_checker_if.sv | 25 ++
 rtl/gate_expect.sv | 21 ++
 rtl/gate_truth_checker.sv | 100 ++++++++++
 tb/tb_gate_truth_checker.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/gate_chk_pkg.sv
// Shared definitions for the mux gate-bank checker: FSM states and gate bit positions.
package gate_chk_pkg;

   localparam int NUM_GATES = 7;

   localparam int G_AND  = 0;
   localparam int G_OR   = 1;
   localparam int G_NAND = 2;
   localparam int G_NOR  = 3;
   localparam int G_XOR  = 4;
   localparam int G_NOT  = 5;
   localparam int G_XNOR = 6;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRIVE = 2'd1,
      ST_CHECK = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

endpackage

// File: rtl/gate_truth_checker_if.sv
// Handshake, operand and result bundle between a self-test controller and the checker.
interface gate_truth_checker_if;
   import gate_chk_pkg::*;

   logic                 start;
   logic                 a;
   logic                 b;
   logic [NUM_GATES-1:0] x_in;
   logic                 busy;
   logic                 done;
   logic                 pass;
   logic [NUM_GATES-1:0] fail_mask;
   logic [2:0]           first_fail;

   modport master (
      output start, x_in,
      input  a, b, busy, done, pass, fail_mask, first_fail
   );

   modport slave (
      input  start, x_in,
      output a, b, busy, done, pass, fail_mask, first_fail
   );

endinterface

// File: rtl/gate_expect.sv
// Golden truth table of the seven-gate bank for one (a, b) operand pair.
module gate_expect
   import gate_chk_pkg::*;
(
   input  logic                 a,
   input  logic                 b,
   output logic [NUM_GATES-1:0] x_exp
);

   always_comb begin
      x_exp         = '0;
      x_exp[G_AND]  = a & b;
      x_exp[G_OR]   = a | b;
      x_exp[G_NAND] = ~(a & b);
      x_exp[G_NOR]  = ~(a | b);
      x_exp[G_XOR]  = a ^ b;
      x_exp[G_NOT]  = ~a;
      x_exp[G_XNOR] = ~(a ^ b);
   end

endmodule

// File: rtl/gate_truth_checker.sv
// Sweeps the four operand pairs through the gate bank, compares against the golden
// table and reports sticky per-gate failures under a start/busy/done handshake.
module gate_truth_checker
   import gate_chk_pkg::*;
#(
   parameter int SETTLE = 1,
   parameter int REPEAT = 1
) (
   input logic           clk,
   input logic           rst,
   gate_truth_checker_if.slave bus
);

   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);
   localparam logic [7:0] REPEAT_LAST = 8'(REPEAT - 1);

   state_e               state;
   logic [1:0]           idx;
   logic [3:0]           settle_cnt;
   logic [7:0]           sweep_cnt;
   logic [NUM_GATES-1:0] fail_mask_r;
   logic [2:0]           first_fail_r;
   logic                 pass_r;
   logic                 active;
   logic [NUM_GATES-1:0] x_exp;
   logic [NUM_GATES-1:0] mism;

   assign active = (state == ST_DRIVE) || (state == ST_CHECK);

   assign bus.a          = active & idx[1];
   assign bus.b          = active & idx[0];
   assign bus.busy       = active;
   assign bus.done       = (state == ST_DONE);
   assign bus.pass       = pass_r;
   assign bus.fail_mask  = fail_mask_r;
   assign bus.first_fail = first_fail_r;

   gate_expect u_expect (
      .a     (bus.a),
      .b     (bus.b),
      .x_exp (x_exp)
   );

   // Bank outputs only count while the vector has settled and is being checked
   assign mism = (state == ST_CHECK) ? (bus.x_in ^ x_exp) : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= ST_IDLE;
         idx          <= '0;
         settle_cnt   <= '0;
         sweep_cnt    <= '0;
         fail_mask_r  <= '0;
         first_fail_r <= '0;
         pass_r       <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.start) begin
                  fail_mask_r  <= '0;
                  first_fail_r <= '0;
                  pass_r       <= 1'b0;
                  idx          <= '0;
                  sweep_cnt    <= '0;
                  settle_cnt   <= '0;
                  state        <= ST_DRIVE;
               end
            end
            ST_DRIVE: begin
               if (settle_cnt == SETTLE_LAST) begin
                  settle_cnt <= '0;
                  state      <= ST_CHECK;
               end else begin
                  settle_cnt <= settle_cnt + 4'd1;
               end
            end
            ST_CHECK: begin
               fail_mask_r <= fail_mask_r | mism;
               if (!first_fail_r[2] && (|mism))
                  first_fail_r <= {1'b1, idx};
               if (idx != 2'd3) begin
                  idx   <= idx + 2'd1;
                  state <= ST_DRIVE;
               end else if (sweep_cnt != REPEAT_LAST) begin
                  idx       <= '0;
                  sweep_cnt <= sweep_cnt + 8'd1;
                  state     <= ST_DRIVE;
               end else begin
                  // Fold in this last check so pass is already valid in the done cycle
                  pass_r <= ~|(fail_mask_r | mism);
                  state  <= ST_DONE;
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_gate_truth_checker.sv
// Directed bench for gate_truth_checker: a model gate bank with stuck-at injection.
module tb_gate_truth_checker;
   import gate_chk_pkg::*;

   logic clk = 1'b0;
   logic rst;
   logic [6:0] and_m;
   logic [6:0] or_m;
   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   gate_truth_checker_if ifc ();
   gate_truth_checker_if ifc2 ();

   gate_truth_checker dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc)
   );

   gate_truth_checker #(.SETTLE(3), .REPEAT(2)) dut2 (
      .clk (clk),
      .rst (rst),
      .bus (ifc2)
   );

   // bit6..bit0 = XNOR, NOT a, XOR, NOR, NAND, OR, AND
   function automatic logic [6:0] golden(input logic a, input logic b);
      return {~(a ^ b), ~a, a ^ b, ~(a | b), ~(a & b), a | b, a & b};
   endfunction

   assign ifc.x_in  = (golden(ifc.a, ifc.b) & and_m) | or_m;
   assign ifc2.x_in = golden(ifc2.a, ifc2.b);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      string      name;
      logic [6:0] and_m;
      logic [6:0] or_m;
      logic [6:0] exp_mask;
      logic [2:0] exp_ff;
      logic       exp_pass;
   } vec_t;

   vec_t vt[8];

   task automatic run1(input string name, input logic [6:0] em, input logic [2:0] eff,
                       input logic ep);
      int  k;
      bit  seen;
      bit  walk_ok;
      int  busy_n;
      @(negedge clk);
      ifc.start = 1'b1;
      @(negedge clk);
      ifc.start = 1'b0;
      seen    = 0;
      walk_ok = 1;
      busy_n  = 0;
      for (k = 0; k < 40; k++) begin
         if (k > 0) @(negedge clk);
         if (ifc.done) begin
            seen = 1;
            break;
         end
         if (ifc.busy) busy_n++;
         if ({ifc.a, ifc.b} !== 2'(k / 2)) walk_ok = 0;
      end
      chk({name, "_done_cycle"}, seen ? k : 99, 8);
      chk({name, "_busy_cycles"}, busy_n, 8);
      chk({name, "_ab_walk"}, walk_ok, 1);
      chk({name, "_busy_at_done"}, ifc.busy, 0);
      chk({name, "_fail_mask"}, ifc.fail_mask, em);
      chk({name, "_first_fail"}, ifc.first_fail, eff);
      chk({name, "_pass"}, ifc.pass, ep);
      @(negedge clk);
      chk({name, "_pass_held"}, ifc.pass, ep);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int  k;
      bit  seen;
      int  busy_n;
      int  d1;
      int  d2;
      logic b9, b10, p8, p9, p10;

      vt[0] = '{"correct",   7'h7F,       7'h00,       7'b0000000, 3'b000, 1'b1};
      vt[1] = '{"xor_st0",   7'b1101111,  7'h00,       7'b0010000, 3'b101, 1'b0};
      vt[2] = '{"not_st1",   7'h7F,       7'b0100000,  7'b0100000, 3'b110, 1'b0};
      vt[3] = '{"and_st1",   7'h7F,       7'b0000001,  7'b0000001, 3'b100, 1'b0};
      vt[4] = '{"nand_st0",  7'b1111011,  7'h00,       7'b0000100, 3'b100, 1'b0};
      vt[5] = '{"xnor_st1",  7'h7F,       7'b1000000,  7'b1000000, 3'b101, 1'b0};
      vt[6] = '{"and0_nor1", 7'b1111110,  7'b0001000,  7'b0001001, 3'b101, 1'b0};
      vt[7] = '{"correct2",  7'h7F,       7'h00,       7'b0000000, 3'b000, 1'b1};

      rst        = 1'b1;
      ifc.start  = 1'b0;
      ifc2.start = 1'b0;
      and_m      = 7'h7F;
      or_m       = 7'h00;
      repeat (2) @(negedge clk);
      chk("reset_outputs", {ifc.a, ifc.b, ifc.busy, ifc.done, ifc.pass, ifc.fail_mask,
                            ifc.first_fail}, 0);
      chk("reset_outputs2", {ifc2.a, ifc2.b, ifc2.busy, ifc2.done, ifc2.pass,
                             ifc2.fail_mask, ifc2.first_fail}, 0);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 8; i++) begin
         and_m = vt[i].and_m;
         or_m  = vt[i].or_m;
         run1(vt[i].name, vt[i].exp_mask, vt[i].exp_ff, vt[i].exp_pass);
      end

      // SETTLE=3, REPEAT=2 instance
      ifc2.start = 1'b1;
      @(negedge clk);
      ifc2.start = 1'b0;
      seen   = 0;
      busy_n = 0;
      for (k = 0; k < 80; k++) begin
         if (k > 0) @(negedge clk);
         if (ifc2.done) begin
            seen = 1;
            break;
         end
         if (ifc2.busy) busy_n++;
      end
      chk("param_done_cycle", seen ? k : 999, 32);
      chk("param_busy_cycles", busy_n, 32);
      chk("param_pass", ifc2.pass, 1);
      chk("param_fail_mask", ifc2.fail_mask, 0);

      // start during CHECK is ignored and not queued
      and_m = 7'h7F;
      or_m  = 7'h00;
      @(negedge clk);
      ifc.start = 1'b1;
      @(negedge clk);
      ifc.start = 1'b0;
      seen = 0;
      for (k = 0; k < 40; k++) begin
         if (k > 0) @(negedge clk);
         if (k == 1) ifc.start = 1'b1;
         if (k == 2) ifc.start = 1'b0;
         if (ifc.done) begin
            seen = 1;
            break;
         end
      end
      chk("midstart_done_cycle", seen ? k : 99, 8);
      @(negedge clk);
      chk("midstart_not_queued1", ifc.busy, 0);
      @(negedge clk);
      chk("midstart_not_queued2", ifc.busy, 0);

      // asynchronous abort part-way through a failing run
      and_m = 7'b1101111;
      ifc.start = 1'b1;
      @(negedge clk);
      ifc.start = 1'b0;
      repeat (5) @(negedge clk);
      chk("abort_mask_before", ifc.fail_mask, 7'b0010000);
      rst = 1'b1;
      #1;
      chk("abort_outputs", {ifc.a, ifc.b, ifc.busy, ifc.done, ifc.pass, ifc.fail_mask,
                            ifc.first_fail}, 0);
      @(negedge clk);
      rst  = 1'b0;
      seen = 0;
      repeat (12) begin
         @(negedge clk);
         if (ifc.done) seen = 1;
      end
      chk("abort_no_done", seen, 0);
      and_m = 7'h7F;
      run1("after_abort", 7'b0000000, 3'b000, 1'b1);

      // back-to-back with start held high
      @(negedge clk);
      ifc.start = 1'b1;
      @(negedge clk);
      d1 = -1; d2 = -1;
      b9 = 1'bx; b10 = 1'bx; p8 = 1'bx; p9 = 1'bx; p10 = 1'bx;
      for (k = 0; k < 40; k++) begin
         if (k > 0) @(negedge clk);
         if (ifc.done) begin
            if (d1 < 0) d1 = k;
            else if (d2 < 0) d2 = k;
         end
         if (k == 8) p8 = ifc.pass;
         if (k == 9) begin
            b9 = ifc.busy;
            p9 = ifc.pass;
         end
         if (k == 10) begin
            b10 = ifc.busy;
            p10 = ifc.pass;
            ifc.start = 1'b0;
         end
         if (d2 >= 0) break;
      end
      chk("b2b_first_done", d1, 8);
      chk("b2b_pass_at_done", p8, 1);
      chk("b2b_gap_idle", b9, 0);
      chk("b2b_pass_in_gap", p9, 1);
      chk("b2b_busy_rise", b10, 1);
      chk("b2b_pass_cleared", p10, 0);
      chk("b2b_second_done", d2, 18);
      chk("b2b_second_pass", ifc.pass, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
